// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: top FSM encoding,
// reply byte values and UART frame geometry.
package uart_program_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_ACK,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] ACK_BYTE = 8'hAA;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

endpackage

// File: rtl/uart_program_loader_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, start-bit glitch rejection,
// mid-bit sampling; one-cycle rx_valid_o pulse with data and framing flag.
module uart_rx_byte
  import uart_program_loader_pkg::*;
#(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_ferr_o
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e      st_q, st_d;
  logic           sync1_q, sync2_q, prev_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) st_d = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          valid_d = 1'b1;
          data_d  = shift_q;
          ferr_d  = !sync2_q;
          st_d    = RX_IDLE;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign rx_valid_o = valid_q;
  assign rx_data_o  = data_q;
  assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: length-prefixed program over UART into instruction memory, then ack and core release.
// Define LOADER_CHECKSUM_EN to require a trailing sum-mod-256 byte over all data bytes.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  localparam int IW = ADDR_W - 2;
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [31:0]   CAP        = 32'd1 << IW;
  localparam logic [CW-1:0] FULL_M1    = CW'(CLK_PER_BIT - 1);
  localparam logic [3:0]    FRAME_LAST = 4'(FRAME_BITS - 1);
`ifdef LOADER_CHECKSUM_EN
  localparam state_e AFTER_DATA = S_CSUM;
`else
  localparam state_e AFTER_DATA = S_ACK;
`endif

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_data;

  uart_rx_byte #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (uart_rx),
    .rx_valid_o(rx_valid),
    .rx_data_o (rx_data),
    .rx_ferr_o (rx_ferr)
  );

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d, last_q, last_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [31:0]           word_q, word_d, assembled;
  logic [7:0]            csum_q, csum_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [31:0]           din_q, din_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic                  tx_busy_q, tx_busy_d, tx_sent_q, tx_sent_d;
  logic                  tx_load, tx_done;
  logic [7:0]            tx_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LEN;
      idx_q      <= '0;
      last_q     <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_busy_q  <= 1'b0;
      tx_sent_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_busy_q  <= tx_busy_d;
      tx_sent_q  <= tx_sent_d;
    end
  end

  assign assembled = {rx_data, word_q[31:8]};
  assign tx_done   = tx_busy_q && (tx_cnt_q == FULL_M1) && (tx_bit_q == FRAME_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    tx_load = 1'b0;
    tx_byte = ACK_BYTE;
    case (state_q)
      S_LEN: begin
        if (rx_valid && rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          word_d = assembled;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Keep N-1 so a full-capacity load ends without the index wrapping.
            last_d = assembled[IW-1:0] - IW'(1);
            if (assembled > CAP)        state_d = S_ERR;
            else if (assembled == 32'd0) state_d = AFTER_DATA;
            else                        state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid && rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          word_d = assembled;
          bcnt_d = bcnt_q + 2'd1;
          csum_d = csum_q + rx_data;
          if (bcnt_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = {idx_q, 2'b00};
            din_d  = assembled;
            idx_d  = idx_q + IW'(1);
            if (idx_q == last_q) state_d = AFTER_DATA;
          end
        end
      end
      S_CSUM: begin
        if (rx_valid) state_d = (!rx_ferr && rx_data == csum_q) ? S_ACK : S_ERR;
      end
      S_ACK: begin
        if (!tx_sent_q)   tx_load = 1'b1;
        else if (tx_done) state_d = S_DONE;
      end
      S_ERR: begin
        tx_byte = ERR_BYTE;
        if (!tx_sent_q) tx_load = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_busy_d  = tx_busy_q;
    tx_sent_d  = tx_sent_q;
    if (tx_load) begin
      tx_shift_d = {1'b1, tx_byte, 1'b0};
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_busy_d  = 1'b1;
      tx_sent_d  = 1'b1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == FULL_M1) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[FRAME_BITS-1:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
        if (tx_bit_q == FRAME_LAST) tx_busy_d = 1'b0;
      end else begin
        tx_cnt_d = tx_cnt_q + CW'(1);
      end
    end
  end

  assign uart_tx   = tx_shift_q[0];
  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_din  = din_q;
  assign core_rst  = (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader with a byte-level reference model.
module tb_uart_program_loader;

  localparam int CPB = 16;
  localparam int AW  = 5;
  localparam int CAP = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic          uart_tx, imem_we, core_rst, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_din;

  uart_program_loader #(.CLK_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .imem_we  (imem_we),
    .imem_addr(imem_addr),
    .imem_din (imem_din),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]    stim_q[$];
  logic [7:0]    tx_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_din_q[$];
  int            tx_start_cyc = -1;
  int            done_rise_cyc = -1;
  int            last_we_cyc = -1;
  logic          done_prev = 1'b0;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_din_q.push_back(imem_din);
      last_we_cyc = cyc;
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
    done_prev = done;
  end

  // Serial decoder for uart_tx, sampling at mid-bit.
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        tx_start_cyc = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        tx_q.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_stim();
    foreach (stim_q[i]) send_byte(stim_q[i], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    tx_q.delete();
    wr_addr_q.delete();
    wr_din_q.delete();
    tx_start_cyc = -1;
    done_rise_cyc = -1;
    last_we_cyc = -1;
    rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic append_csum();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] s = 8'h00;
    for (int i = 4; i < stim_q.size(); i++) s = s + stim_q[i];
    stim_q.push_back(s);
`endif
  endtask

  task automatic gen_load(input int n);
    logic [31:0] nl = 32'(n);
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(nl[8*i +: 8]);
    for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    append_csum();
  endtask

  task automatic wait_tx(input string name);
    int t = 0;
    while (tx_q.size() == 0 && t < 40 * CPB) begin
      @(posedge clk);
      t++;
    end
    t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 4 * CPB) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    vectors++;
    if (tx_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s tx_timeout: got %0d tx bytes, need 1", name, tx_q.size());
    end
  endtask

  // Reference model: parse the byte stream per the protocol, then compare.
  task automatic check_load(input string name);
    logic [31:0]   n;
    logic [7:0]    sum = 8'h00;
    logic          exp_err;
    logic [7:0]    exp_tx, got_tx;
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_din[$];
    n = {stim_q[3], stim_q[2], stim_q[1], stim_q[0]};
    exp_err = (n > 32'(CAP));
    if (!exp_err) begin
      for (int w = 0; w < int'(n); w++) begin
        exp_addr.push_back(AW'(w * 4));
        exp_din.push_back({stim_q[4*w+7], stim_q[4*w+6], stim_q[4*w+5], stim_q[4*w+4]});
        for (int k = 4; k < 8; k++) sum = sum + stim_q[4*w+k];
      end
`ifdef LOADER_CHECKSUM_EN
      exp_err = (stim_q[4 + 4*int'(n)] != sum);
`endif
    end
    exp_tx = exp_err ? 8'hEE : 8'hAA;
    got_tx = 8'h00;
    if (tx_q.size() > 0) got_tx = tx_q[0];

    vectors++;
    if (wr_addr_q.size() != exp_addr.size()) begin
      miscompares++;
      $display("FAIL %s write_count: got %0d, need %0d", name, wr_addr_q.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < wr_addr_q.size(); i++) begin
      vectors++;
      if (wr_addr_q[i] !== exp_addr[i] || wr_din_q[i] !== exp_din[i]) begin
        miscompares++;
        $display("FAIL %s write[%0d]: got addr %h din %h, need addr %h din %h",
                 name, i, wr_addr_q[i], wr_din_q[i], exp_addr[i], exp_din[i]);
      end
    end
    vectors++;
    if (got_tx !== exp_tx) begin
      miscompares++;
      $display("FAIL %s tx_byte: got %h, need %h", name, got_tx, exp_tx);
    end
    vectors++;
    if (done !== !exp_err || error !== exp_err || core_rst !== exp_err) begin
      miscompares++;
      $display("FAIL %s status: got done=%b error=%b core_rst=%b, need done=%b error=%b core_rst=%b",
               name, done, error, core_rst, !exp_err, exp_err, exp_err);
    end
    if (!exp_err) begin
      vectors++;
      if (done_rise_cyc - tx_start_cyc != 10 * CPB) begin
        miscompares++;
        $display("FAIL %s done_latency: got %0d cycles, need %0d", name,
                 done_rise_cyc - tx_start_cyc, 10 * CPB);
      end
`ifndef LOADER_CHECKSUM_EN
      if (n != 0) begin
        vectors++;
        if (tx_start_cyc != last_we_cyc + 1) begin
          miscompares++;
          $display("FAIL %s ack_start: got cycle %0d, need %0d", name, tx_start_cyc, last_we_cyc + 1);
        end
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (uart_tx !== 1'b1 || imem_we !== 1'b0 || imem_addr !== '0 || imem_din !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_datapath: got tx=%b we=%b addr=%h din=%h, need 1 0 0 0",
               uart_tx, imem_we, imem_addr, imem_din);
    end
    vectors++;
    if (core_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: got core_rst=%b done=%b error=%b, need 1 0 0", core_rst, done, error);
    end
  endtask

  task automatic test_basic();
    do_reset();
    stim_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'hEF, 8'hBE, 8'hAD, 8'hDE};
    append_csum();
    send_stim();
    wait_tx("basic");
    check_load("basic");
    vectors++;
    if (wr_din_q.size() < 2 || wr_addr_q[1] !== AW'(4) || wr_din_q[1] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL basic_word1: got %0d writes, need addr 04 din deadbeef", wr_din_q.size());
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    stim_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    append_csum();
    send_stim();
    wait_tx("zero_len");
    check_load("zero_len");
    send_byte(8'h55, 1'b1);
    send_byte(8'h12, 1'b0);
    repeat (12 * CPB) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (wr_addr_q.size() != 0 || tx_q.size() != 1 || done !== 1'b1 || core_rst !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_after_done: got writes=%0d tx=%0d done=%b core_rst=%b error=%b, need 0 1 1 0 0",
               wr_addr_q.size(), tx_q.size(), done, core_rst, error);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    uart_rx = 1'b0;
    repeat (CPB * 3 / 10) @(posedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    gen_load(3);
    send_stim();
    wait_tx("glitch");
    check_load("glitch");
  endtask

  task automatic test_framing();
    do_reset();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    wait_tx("framing");
    vectors++;
    if (tx_q.size() == 0 || tx_q[0] !== 8'hEE || wr_addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL framing_reply: got tx count %0d writes %0d, need one EE byte and 0 writes",
               tx_q.size(), wr_addr_q.size());
    end
    vectors++;
    if (error !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL framing_status: got error=%b core_rst=%b done=%b, need 1 1 0", error, core_rst, done);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (error !== 1'b0 || core_rst !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL framing_rst_clear: got error=%b core_rst=%b done=%b, need 0 1 0", error, core_rst, done);
    end
    // A clean load after the error reset must succeed.
    gen_load(1);
    do_reset();
    send_stim();
    wait_tx("after_err");
    check_load("after_err");
  endtask

  task automatic test_overflow();
    do_reset();
    stim_q.delete();
    stim_q.push_back(8'(CAP + 1));
    stim_q.push_back(8'h00);
    stim_q.push_back(8'h00);
    stim_q.push_back(8'h00);
    send_stim();
    wait_tx("overflow");
    check_load("overflow");
  endtask

  task automatic test_capacity();
    do_reset();
    gen_load(CAP);
    send_stim();
    wait_tx("capacity");
    check_load("capacity");
    vectors++;
    if (wr_addr_q.size() != CAP || wr_addr_q[CAP-1] !== AW'((1 << AW) - 4)) begin
      miscompares++;
      $display("FAIL capacity_last_addr: got %0d writes, need %0d ending at %0d",
               wr_addr_q.size(), CAP, (1 << AW) - 4);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      do_reset();
      gen_load($urandom_range(1, 4));
      send_stim();
      wait_tx("random");
      check_load("random");
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    stim_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h0A};
    send_stim();
    wait_tx("csum_ok");
    check_load("csum_ok");
    do_reset();
    stim_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h0B};
    send_stim();
    wait_tx("csum_bad");
    check_load("csum_bad");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_glitch();
    test_framing();
    test_overflow();
    test_capacity();
    test_random();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
